mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port split RAM (high/low 16-bit halves) between two requesters:
//  the RV2T core and the on-chip debugger (OCD). One access per clock is issued to the RAM.
//  Read data returns one cycle later and is tagged back to its issuing requester.
//  Sits between PulseRain_RV2T_core / OCD logic and the two single_port_ram instances in the MCU.
// PARAMETERS
//  ADDR_BITS      `MEM_ADDR_BITS  word-address width of RAM port
//  XLEN           32              data word width
//  OCD_BURST_MAX  4               max consecutive OCD grants while core is waiting (range 1..15)
// PORTS
//  clk              in   1          system clock
//  reset_n          in   1          asynchronous active-low reset
//  sync_reset       in   1          synchronous reset, same effect as reset_n
//  core_req         in   1          core requests an access this cycle
//  core_addr        in   ADDR_BITS  core word address
//  core_we          in   XLEN/8     core byte write enables (0 = read)
//  core_wdata       in   XLEN       core write data
//  core_gnt         out  1          core access issued to RAM this cycle
//  core_rvalid      out  1          core read data valid
//  core_rdata       out  XLEN       core read data
//  ocd_req          in   1          OCD requests an access this cycle
//  ocd_write        in   1          1 = full-word write, 0 = read
//  ocd_addr         in   ADDR_BITS  OCD word address
//  ocd_wdata        in   XLEN       OCD write data
//  ocd_gnt          out  1          OCD access issued this cycle
//  ocd_rvalid       out  1          OCD read data valid
//  ocd_rdata        out  XLEN       OCD read data
//  mem_addr         out  ADDR_BITS  RAM address
//  mem_write_en     out  XLEN/8     RAM byte enables ([3:2] high half, [1:0] low half)
//  mem_write_data   out  XLEN       RAM write data
//  mem_read_data    in   XLEN       RAM registered read data ({dout_high, dout_low})
// BEHAVIOUR
//  - Reset (reset_n low, or sync_reset high at clk edge): streak counter=0, pending-read tag=NONE,
//    last_addr=0; all gnt/rvalid=0, rdata=0, mem_write_en=0, mem_addr=0.
//  - Grant is combinational in the request cycle; requester holds req/addr/data until gnt=1.
//  - Priority: OCD wins by default. Exception: core_req=1 and streak==OCD_BURST_MAX -> core wins.
//  - streak (4 bits): +1 on each OCD grant while core_req=1; cleared on core grant or when
//    core_req=0; saturates at OCD_BURST_MAX.
//  - Granted requester drives mem_addr/mem_write_data; mem_write_en = core_we (core) or
//    4'b1111 if ocd_write (OCD), else 0. No grant: mem_write_en=0, mem_addr holds last_addr.
//  - Read grant (write enables all 0) sets tag=CORE/OCD for next cycle; write grant or idle -> NONE.
//  - Cycle after a read grant: matching *_rvalid=1 for exactly one cycle, *_rdata=mem_read_data
//    (registered copy held until next rvalid for that requester). Latency: gnt -> rvalid = 1 clk.
//  - Back-to-back: a new grant may issue in the same cycle as a prior rvalid; ordering is preserved.
//  - Write immediately followed by read of same address returns new data (RAM write-first).
//  - Reset mid-read: pending tag cleared, no rvalid emitted after reset releases.
//  - Both req=0: no RAM access, no state change except streak clear.
//  - core_gnt and ocd_gnt are never 1 in the same cycle (assertion).
// TESTING
//  1 Core-only read addr 0x10 (RAM=0xDEADBEEF) -> core_gnt same clk, core_rvalid next clk,
//    core_rdata=0xDEADBEEF, ocd_* stay 0.
//  2 Both req continuously, OCD_BURST_MAX=4 -> grant pattern OCD,OCD,OCD,OCD,CORE repeating;
//    core never waits more than 4 cycles.
//  3 OCD write 0x12345678 @0x20 then core read @0x20 next cycle -> mem_write_en=4'hF,
//    core_rdata=0x12345678.
//  4 Core byte write core_we=4'b0100 data 0x00AB0000 over 0xFFFFFFFF -> readback 0xFFABFFFF.
//  5 reset_n pulsed low the cycle after OCD read grant -> ocd_rvalid never asserts; outputs 0.
//  6 sync_reset=1 while both requesting -> no gnt that cycle; streak restarts from 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one split 32-bit single-port RAM between the RV2T
// core and the on-chip debugger. One access is issued per clock. Read data
// comes back one clock later and is steered to the requester that issued it.
module mem_port_arbiter #(
  parameter int ADDR_BITS     = 14,
  parameter int XLEN          = 32,
  parameter int OCD_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sync_reset,
  input  logic                  core_req,
  input  logic [ADDR_BITS-1:0]  core_addr,
  input  logic [XLEN/8-1:0]     core_we,
  input  logic [XLEN-1:0]       core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [XLEN-1:0]       core_rdata,
  input  logic                  ocd_req,
  input  logic                  ocd_write,
  input  logic [ADDR_BITS-1:0]  ocd_addr,
  input  logic [XLEN-1:0]       ocd_wdata,
  output logic                  ocd_gnt,
  output logic                  ocd_rvalid,
  output logic [XLEN-1:0]       ocd_rdata,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [XLEN/8-1:0]     mem_write_en,
  output logic [XLEN-1:0]       mem_write_data,
  input  logic [XLEN-1:0]       mem_read_data
);

  // Owner of the read currently in flight through the RAM output register.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CORE = 2'd1,
    TAG_OCD  = 2'd2
  } tag_t;

  logic [3:0]           r_streak;
  tag_t                 r_tag_p1;
  logic [ADDR_BITS-1:0] r_last_addr;
  logic [XLEN-1:0]      r_core_rdata;
  logic [XLEN-1:0]      r_ocd_rdata;

  logic w_active;
  logic w_streak_full;
  logic w_core_wins;
  logic w_core_gnt;
  logic w_ocd_gnt;
  logic w_core_rd;
  logic w_ocd_rd;

  // Stage p0: request arbitration. OCD wins unless the core has been starved
  // for OCD_BURST_MAX consecutive OCD grants. Nothing is granted in reset.
  assign w_active      = reset_n & ~sync_reset;
  assign w_streak_full = (r_streak == 4'(OCD_BURST_MAX));
  assign w_core_wins   = core_req & (w_streak_full | ~ocd_req);
  assign w_core_gnt    = w_active & w_core_wins;
  assign w_ocd_gnt     = w_active & ocd_req & ~w_core_wins;
  assign w_core_rd     = w_core_gnt & (core_we == '0);
  assign w_ocd_rd      = w_ocd_gnt & ~ocd_write;

  assign core_gnt = w_core_gnt;
  assign ocd_gnt  = w_ocd_gnt;

  // RAM port mux: granted requester drives the port; idle keeps the last address.
  always_comb begin
    mem_addr       = r_last_addr;
    mem_write_en   = '0;
    mem_write_data = '0;
    if (!w_active) begin
      mem_addr = '0;
    end else if (w_core_gnt) begin
      mem_addr       = core_addr;
      mem_write_en   = core_we;
      mem_write_data = core_wdata;
    end else if (w_ocd_gnt) begin
      mem_addr       = ocd_addr;
      mem_write_en   = ocd_write ? '1 : '0;
      mem_write_data = ocd_wdata;
    end
  end

  // Stage p1: RAM read data is valid now; steer it to the tagged requester,
  // otherwise present the last value that requester received.
  assign core_rvalid = w_active & (r_tag_p1 == TAG_CORE);
  assign ocd_rvalid  = w_active & (r_tag_p1 == TAG_OCD);
  assign core_rdata  = core_rvalid ? mem_read_data : r_core_rdata;
  assign ocd_rdata   = ocd_rvalid  ? mem_read_data : r_ocd_rdata;

  // Arbitration state, read tag and held read data; both resets clear everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_streak     <= '0;
      r_tag_p1     <= TAG_NONE;
      r_last_addr  <= '0;
      r_core_rdata <= '0;
      r_ocd_rdata  <= '0;
    end else if (sync_reset) begin
      r_streak     <= '0;
      r_tag_p1     <= TAG_NONE;
      r_last_addr  <= '0;
      r_core_rdata <= '0;
      r_ocd_rdata  <= '0;
    end else begin
      if (!core_req || w_core_gnt) begin
        r_streak <= '0;
      end else if (w_ocd_gnt && !w_streak_full) begin
        r_streak <= r_streak + 4'd1;
      end

      if (w_core_rd) begin
        r_tag_p1 <= TAG_CORE;
      end else if (w_ocd_rd) begin
        r_tag_p1 <= TAG_OCD;
      end else begin
        r_tag_p1 <= TAG_NONE;
      end

      if (w_core_gnt || w_ocd_gnt) begin
        r_last_addr <= mem_addr;
      end

      if (r_tag_p1 == TAG_CORE) begin
        r_core_rdata <= mem_read_data;
      end
      if (r_tag_p1 == TAG_OCD) begin
        r_ocd_rdata <= mem_read_data;
      end
    end
  end

  // The RAM port can only carry one access per clock.
  a_single_grant: assert property (@(posedge clk) disable iff (!reset_n)
    !(core_gnt && ocd_gnt));

endmodule
